// File: rtl/lsu_pkg.sv
// Shared LSU definitions: RV32I width codes, FSM states, byte masks.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

    localparam logic [3:0] BM_NONE = 4'b0000;
    localparam logic [3:0] BM_B    = 4'b0001;
    localparam logic [3:0] BM_H    = 4'b0011;
    localparam logic [3:0] BM_W    = 4'b1111;

    // Access size in bytes; undefined codes count as one byte.
    function automatic logic [2:0] acc_size(logic [2:0] f3);
        case (f3)
            F3_H, F3_HU: acc_size = 3'd2;
            F3_W:        acc_size = 3'd4;
            default:     acc_size = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// Core request/response handshake plus data-memory bus of the LSU initiator.
interface lsu_mem_initiator_if #(
    parameter int DEPTH = 2048
);
    localparam int AW = $clog2(DEPTH);

    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_misalign;
    logic          rsp_fault;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_bmask;
    logic [31:0]   mem_wdata;
    logic          mem_wren;
    logic [31:0]   mem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  rsp_ready, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_misalign, rsp_fault,
        output mem_addr, mem_bmask, mem_wdata, mem_wren
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output rsp_ready, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_misalign, rsp_fault,
        input  mem_addr, mem_bmask, mem_wdata, mem_wren
    );

endinterface

// File: rtl/lsu_load_extend.sv
// Load data extension: selects the low byte/half/word and sign- or zero-extends.
module lsu_load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (funct3)
            F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
            F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   ext = {24'd0, raw[7:0]};
            F3_HU:   ext = {16'd0, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// LSU memory initiator: one load/store in flight, IDLE -> ACCESS -> RESP.
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int DEPTH = 2048
) (
    input logic                 i_clk,
    input logic                 i_reset,
    lsu_mem_initiator_if.master bus
);

    localparam int AW = $clog2(DEPTH);

    lsu_state_e    state_q;
    logic          we_q;
    logic [2:0]    f3_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q;
    logic          mis_q;
    logic          fault_q;

    logic          illegal;
    logic          misalign;
    logic          oob;
    logic [32:0]   end_addr;
    logic [31:0]   ext;
    logic [3:0]    st_mask;

    // Error decode on the raw request; 33-bit sum keeps OOB from wrapping.
    always_comb begin
        illegal  = bus.req_we ? (bus.req_funct3 > F3_W)
                              : (bus.req_funct3 inside {3'b011, 3'b110, 3'b111});
        misalign = ((bus.req_funct3 == F3_H || bus.req_funct3 == F3_HU)
                    && bus.req_addr[0])
                || (bus.req_funct3 == F3_W && bus.req_addr[1:0] != 2'b00);
        end_addr = {1'b0, bus.req_addr} + 33'(acc_size(bus.req_funct3));
        oob      = end_addr > 33'(DEPTH);
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            f3_q    <= 3'd0;
            addr_q  <= '0;
            wdata_q <= 32'd0;
            rdata_q <= 32'd0;
            mis_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.req_valid) begin
                        we_q    <= bus.req_we;
                        f3_q    <= bus.req_funct3;
                        addr_q  <= bus.req_addr[AW-1:0];
                        wdata_q <= bus.req_wdata;
                        rdata_q <= 32'd0;
                        mis_q   <= misalign;
                        fault_q <= illegal | oob;
                        state_q <= (illegal | oob | misalign) ? ST_RESP
                                                              : ST_ACCESS;
                    end
                end
                ST_ACCESS: begin
                    if (!we_q)
                        rdata_q <= ext;
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    if (bus.rsp_ready)
                        state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    always_comb begin
        st_mask = BM_B;
        if (f3_q == F3_H)
            st_mask = BM_H;
        else if (f3_q == F3_W)
            st_mask = BM_W;
    end

    assign bus.mem_wren  = (state_q == ST_ACCESS) && we_q;
    assign bus.mem_bmask = bus.mem_wren ? st_mask : BM_NONE;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q & {{8{bus.mem_bmask[3]}}, {8{bus.mem_bmask[2]}},
                                      {8{bus.mem_bmask[1]}}, {8{bus.mem_bmask[0]}}};

    assign bus.req_ready    = (state_q == ST_IDLE);
    assign bus.rsp_valid    = (state_q == ST_RESP);
    assign bus.rsp_rdata    = rdata_q;
    assign bus.rsp_misalign = mis_q;
    assign bus.rsp_fault    = fault_q;

    lsu_load_extend u_ext (
        .funct3 (f3_q),
        .raw    (bus.mem_rdata),
        .ext    (ext)
    );

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// Scoreboard bench for lsu_mem_initiator with a byte-array memory and reference model.
module tb_lsu_mem_initiator;

    localparam int DEPTH = 2048;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
        logic        fault;
        int          first;
    } rsp_t;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  bmask;
        logic [31:0] wdata;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    lsu_mem_initiator_if #(.DEPTH(DEPTH)) bus();

    lsu_mem_initiator #(.DEPTH(DEPTH)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    logic [7:0] dmem    [DEPTH];
    logic [7:0] ref_mem [DEPTH];

    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    rsp_t sq[$];
    wr_t  wq[$];
    bit   quiet = 1'b0;
    int   hold  = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Data memory: combinational read, byte-masked write.
    always_comb begin
        bus.mem_rdata = 32'd0;
        for (int i = 0; i < 4; i++)
            if (int'(bus.mem_addr) + i < DEPTH)
                bus.mem_rdata[8*i +: 8] = dmem[int'(bus.mem_addr) + i];
    end

    always @(posedge clk)
        if (bus.mem_wren)
            for (int i = 0; i < 4; i++)
                if (bus.mem_bmask[i] && int'(bus.mem_addr) + i < DEPTH)
                    dmem[int'(bus.mem_addr) + i] <= bus.mem_wdata[8*i +: 8];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic fail_now(string name);
        tests++;
        fails++;
        $display("FAIL %s: got event expected none", name);
    endtask

    // Reference model: plain byte-array semantics of RV32I loads/stores.
    task automatic predict(bit we, logic [2:0] f3, logic [31:0] a,
                           logic [31:0] wd, output rsp_t r);
        int          size;
        bit          illegal;
        logic [31:0] raw;
        logic [31:0] lim;
        wr_t         w;
        size    = (f3 == 3'b010) ? 4 : (f3 == 3'b001 || f3 == 3'b101) ? 2 : 1;
        illegal = we ? (f3 > 3'b010) : (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111);
        r.fault = illegal || (longint'(a) + longint'(size) > longint'(DEPTH));
        r.mis   = (size == 2 && a[0]) || (size == 4 && a[1:0] != 2'b00);
        r.rdata = 32'd0;
        r.first = 0;
        if (!r.fault && !r.mis) begin
            lim = (size == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * size)) - 32'd1;
            if (we) begin
                for (int i = 0; i < size; i++)
                    ref_mem[int'(a) + i] = wd[8*i +: 8];
                w.addr  = a;
                w.bmask = 4'((1 << size) - 1);
                w.wdata = wd & lim;
                wq.push_back(w);
            end else begin
                raw = 32'd0;
                for (int i = 0; i < size; i++)
                    raw[8*i +: 8] = ref_mem[int'(a) + i];
                if (!f3[2] && size < 4 && raw[8*size - 1])
                    raw = raw - (32'd1 << (8 * size));
                r.rdata = raw;
            end
        end
    endtask

    task automatic issue(bit we, logic [2:0] f3, logic [31:0] a,
                         logic [31:0] wd, bit track = 1'b1);
        rsp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!bus.req_ready) begin
            if (n > 200) begin
                fail_now("req_ready_timeout");
                return;
            end
            n++;
            @(negedge clk);
        end
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        if (track) begin
            predict(we, f3, a, wd, e);
            e.first = cyc + 1 + ((e.fault || e.mis) ? 0 : 1);
            sq.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'($urandom);
        bus.req_funct3 = 3'($urandom);
        bus.req_addr   = $urandom;
        bus.req_wdata  = $urandom;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((sq.size() != 0 || !bus.req_ready) && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (n >= 300)
            fail_now("drain_timeout");
    endtask

    // Monitor: checks memory writes and responses against the queues.
    initial begin
        rsp_t cur;
        wr_t  w;
        bit   have;
        have = 1'b0;
        bus.rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || quiet) begin
                have = 1'b0;
                bus.rsp_ready = 1'b0;
            end else begin
                if (bus.mem_wren) begin
                    if (wq.size() == 0) begin
                        fail_now("spurious_wren");
                    end else begin
                        w = wq.pop_front();
                        chk("wr_addr", 32'(bus.mem_addr), w.addr);
                        chk("wr_bmask", 32'(bus.mem_bmask), 32'(w.bmask));
                        chk("wr_wdata", bus.mem_wdata, w.wdata);
                    end
                end else begin
                    chk("bmask_idle", 32'(bus.mem_bmask), 32'd0);
                end
                if (bus.rsp_valid) begin
                    if (!have) begin
                        if (sq.size() == 0) begin
                            fail_now("unexpected_rsp");
                        end else begin
                            cur  = sq.pop_front();
                            have = 1'b1;
                            chk("rsp_latency", cyc, cur.first);
                        end
                    end
                    if (have) begin
                        chk("rsp_rdata", bus.rsp_rdata, cur.rdata);
                        chk("rsp_misalign", 32'(bus.rsp_misalign), 32'(cur.mis));
                        chk("rsp_fault", 32'(bus.rsp_fault), 32'(cur.fault));
                        chk("req_ready_busy", 32'(bus.req_ready), 32'd0);
                    end
                    if (hold > 0) begin
                        bus.rsp_ready = 1'b0;
                        hold--;
                    end else begin
                        bus.rsp_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (bus.rsp_ready)
                        have = 1'b0;
                end else begin
                    bus.rsp_ready = 1'($urandom_range(0, 1));
                end
            end
        end
    end

    task automatic chk_reset_outputs(string tag);
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_rsp_rdata"}, bus.rsp_rdata, 32'd0);
        chk({tag, "_misalign"}, 32'(bus.rsp_misalign), 32'd0);
        chk({tag, "_fault"}, 32'(bus.rsp_fault), 32'd0);
        chk({tag, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
        chk({tag, "_mem_bmask"}, 32'(bus.mem_bmask), 32'd0);
        chk({tag, "_mem_wdata"}, bus.mem_wdata, 32'd0);
        chk({tag, "_mem_wren"}, 32'(bus.mem_wren), 32'd0);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        logic [2:0] legal [5];
        logic [7:0] v;
        int         n;
        legal = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        for (int i = 0; i < DEPTH; i++) begin
            v = 8'($urandom);
            dmem[i]    <= v;
            ref_mem[i]  = v;
        end

        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");
        rst = 1'b0;

        issue(1'b1, 3'b010, 32'h10, 32'hDEADBEEF);
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        issue(1'b1, 3'b000, 32'h21, 32'h12345680);
        issue(1'b0, 3'b000, 32'h21, 32'h0);
        issue(1'b0, 3'b100, 32'h21, 32'h0);
        issue(1'b0, 3'b100, 32'h20, 32'h0);
        issue(1'b0, 3'b100, 32'h22, 32'h0);
        issue(1'b0, 3'b001, 32'h13, 32'h0);
        issue(1'b0, 3'b010, 32'h7FE, 32'h0);
        issue(1'b0, 3'b000, 32'h7FF, 32'h0);
        issue(1'b1, 3'b011, 32'h30, 32'hCAFEF00D);
        issue(1'b0, 3'b010, 32'h30, 32'h0);
        issue(1'b1, 3'b001, 32'h44, 32'hFFFF8001);
        issue(1'b0, 3'b001, 32'h44, 32'h0);
        issue(1'b0, 3'b101, 32'h44, 32'h0);
        issue(1'b0, 3'b000, 32'h800, 32'h0);
        drain();

        hold = 5;
        issue(1'b0, 3'b010, 32'h10, 32'h0);
        drain();
        chk("hold_consumed", 32'(hold), 32'd0);

        for (int k = 0; k < 300; k++) begin
            bit          we;
            logic [2:0]  f3;
            logic [31:0] a;
            int          r;
            we = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0)
                f3 = 3'($urandom);
            else
                f3 = legal[we ? $urandom_range(0, 2) : $urandom_range(0, 4)];
            r = $urandom_range(0, 9);
            if (r == 0)
                a = $urandom;
            else if (r == 1)
                a = DEPTH - $urandom_range(1, 8);
            else
                a = 32'h100 + $urandom_range(0, 63);
            if (r > 3)
                a = a & ~32'h3;
            issue(we, f3, a, $urandom);
        end
        drain();

        quiet = 1'b1;
        issue(1'b1, 3'b010, 32'h40, 32'h12345678, 1'b0);
        @(negedge clk);
        chk("rst_pre_wren", 32'(bus.mem_wren), 32'd1);
        rst = 1'b1;
        #1;
        chk_reset_outputs("midreset");
        @(negedge clk);
        rst = 1'b0;
        quiet = 1'b0;
        issue(1'b0, 3'b010, 32'h40, 32'h0);
        drain();

        n = 0;
        for (int i = 0; i < DEPTH; i++)
            if (dmem[i] !== ref_mem[i])
                n++;
        chk("mem_image_mismatches", 32'(n), 32'd0);
        chk("pending_writes", 32'(wq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
